hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Generates the execute-stage operand forwarding selects.
- Detects load-use hazards and inserts bubbles.
- Flushes the F/D and D/E registers on a taken branch.
- Sequences multi-cycle execute operations (multiply) through a small FSM that stalls the front of the pipe until the operation completes.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MC_LATENCY, 4, total execute cycles of a multi-cycle op; legal range 2..15.
- RA_BITS, 4, register address width.
- PERF_BITS, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- Ra1D, Ra2D  in  RA_BITS  source registers of the decode-stage instruction
- Ra1E, Ra2E  in  RA_BITS  source registers of the execute-stage instruction
- WA3E, WA3M, WA3W  in  RA_BITS  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  condition-qualified write enables in M/W
- MemtoRegE  in  1  execute-stage instruction is a load
- BranchTakenE  in  1  condition-qualified branch taken, from the condition unit
- MultiStartE  in  1  condition-qualified multi-cycle op enters E this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- StallF, StallD, StallE  out  1  hold the PC, F/D and D/E registers
- FlushD, FlushE, FlushM  out  1  clear the F/D, D/E and E/M registers to a bubble
- MultiBusy  out  1  FSM in BUSY
- MultiDoneE  out  1  one-cycle pulse: capture the multi-cycle result this cycle
- StallCycles  out  PERF_BITS  saturating count of cycles with StallD=1

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE; the counter and StallCycles clear to 0.
  - While reset is low: FlushD=FlushE=FlushM=1; all stalls, forwards, MultiBusy and MultiDoneE are 0.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and WA3M==Ra1E and Ra1E!=15.
  - Otherwise 01 if RegWriteW and WA3W==Ra1E and Ra1E!=15.
  - Otherwise 00.
  - M has priority over W.
  - ForwardBE uses the same rules with Ra2E.
  - R15 is never forwarded.
- Load-use hazard:
  - LdStall = MemtoRegE and (WA3E==Ra1D or WA3E==Ra2D).
  - LdStall drives StallF=StallD=1 and FlushE=1 for that cycle.
- Branch:
  - BranchTakenE=1 drives FlushD=1 and FlushE=1 in the same cycle.
  - Branch flush overrides LdStall: StallF and StallD are forced to 0 so the redirected PC loads.
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE to BUSY when MultiStartE=1 and BranchTakenE=0; the counter loads MC_LATENCY-2.
  - BUSY: StallF=StallD=StallE=1, FlushM=1 (bubbles into M), MultiBusy=1. The counter decrements each cycle; at counter==0 it goes to DONE.
  - DONE: one cycle with MultiDoneE=1. There are no stalls from the FSM and the E instruction advances. Next state is IDLE, or BUSY again if MultiStartE=1 (back-to-back ops).
  - Latency: the op occupies E for exactly MC_LATENCY cycles, counting the start cycle; the start cycle itself is not stalled by the FSM.
  - MultiStartE is ignored while in BUSY.
- Priority:
  - While BUSY, the FSM stalls dominate. LdStall and BranchTakenE are masked, because the E instruction is frozen and any branch resolves later.
  - FlushE is 0 in BUSY.
- StallCycles increments on every cycle with StallD=1 and saturates at all-ones (no wrap).
- Reset asserted mid-operation aborts the op immediately: next state IDLE, with no MultiDoneE pulse.

Test Plan:
- Forwarding:
  - RegWriteM=1, WA3M=3, Ra1E=3 -> ForwardAE=10.
  - Add RegWriteW=1, WA3W=3 -> still 10.
  - Clear RegWriteM -> 01.
  - Ra1E=WA3M=15 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, Ra2D=5 -> StallF=StallD=FlushE=1 for one cycle; StallCycles goes 0 to 1.
- Branch vs load-use: BranchTakenE=1 with the same load-use inputs -> FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle op:
  - MC_LATENCY=4, MultiStartE pulse at cycle 0 -> MultiBusy=1 in cycles 1-2 with all three stalls and FlushM=1.
  - MultiDoneE=1 in cycle 3, idle in cycle 4; StallCycles=2.
- Back-to-back: MultiStartE=1 during DONE -> returns to BUSY with no IDLE gap; a second MultiDoneE arrives 3 cycles later.
- Reset mid-BUSY: reset=0 for one cycle during BUSY -> FSM IDLE, StallCycles=0, flushes=1 during reset, no MultiDoneE afterwards.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage F/D/E/M/W pipe: operand forwarding, load-use bubbles,
// branch flushes, multi-cycle execute sequencing and a saturating stall-cycle counter.
module hazard_sequencer #(
  parameter int MC_LATENCY = 4,
  parameter int RA_BITS    = 4,
  parameter int PERF_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RA_BITS-1:0]   Ra1D,
  input  logic [RA_BITS-1:0]   Ra2D,
  input  logic [RA_BITS-1:0]   Ra1E,
  input  logic [RA_BITS-1:0]   Ra2E,
  input  logic [RA_BITS-1:0]   WA3E,
  input  logic [RA_BITS-1:0]   WA3M,
  input  logic [RA_BITS-1:0]   WA3W,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 BranchTakenE,
  input  logic                 MultiStartE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 MultiBusy,
  output logic                 MultiDoneE,
  output logic [PERF_BITS-1:0] StallCycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MC_LATENCY - 2);
  localparam logic [RA_BITS-1:0] PC_REG   = RA_BITS'(15);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PERF_BITS-1:0] stall_cycles_q, stall_cycles_d;

  logic ld_stall;
  logic start_ok;
  logic busy;

  function automatic logic [1:0] fwd_sel(input logic [RA_BITS-1:0] ra);
    if (ra == PC_REG)                   return 2'b00;
    else if (RegWriteM && (WA3M == ra)) return 2'b10;
    else if (RegWriteW && (WA3W == ra)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign ld_stall = MemtoRegE && ((WA3E == Ra1D) || (WA3E == Ra2D));
  assign start_ok = MultiStartE && !BranchTakenE;
  assign busy     = (state_q == S_BUSY);

  // The counter holds the BUSY cycles still to go; DONE follows once it would reach zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? S_DONE : S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MultiBusy  = 1'b0;
    MultiDoneE = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Ra1E);
      ForwardBE = fwd_sel(Ra2E);
      if (busy) begin
        // E is frozen, so load-use and branch are masked until the op drains.
        StallF    = 1'b1;
        StallD    = 1'b1;
        StallE    = 1'b1;
        FlushM    = 1'b1;
        MultiBusy = 1'b1;
      end else begin
        StallF     = ld_stall && !BranchTakenE;
        StallD     = ld_stall && !BranchTakenE;
        FlushD     = BranchTakenE;
        FlushE     = ld_stall || BranchTakenE;
        MultiDoneE = (state_q == S_DONE);
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!reset)                         stall_cycles_d = '0;
    else if (StallD && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  assign StallCycles = stall_cycles_q;

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    cnt_q          <= cnt_d;
    stall_cycles_q <= stall_cycles_d;
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model that tracks how long a multi-cycle op has occupied E.
module tb_hazard_sequencer;

  localparam int L  = 4;
  localparam int RA = 4;
  localparam int PB = 6;
  localparam int PERF_MAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RA-1:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic          reg_write_m, reg_write_w, mem_to_reg_e, branch_taken_e, multi_start_e;
  logic [1:0]    forward_ae, forward_be;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, multi_busy, multi_done_e;
  logic [PB-1:0] stall_cycles;

  hazard_sequencer #(.MC_LATENCY(L), .RA_BITS(RA), .PERF_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .Ra1D(ra1d), .Ra2D(ra2d), .Ra1E(ra1e), .Ra2E(ra2e),
    .WA3E(wa3e), .WA3M(wa3m), .WA3W(wa3w),
    .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .MemtoRegE(mem_to_reg_e), .BranchTakenE(branch_taken_e), .MultiStartE(multi_start_e),
    .ForwardAE(forward_ae), .ForwardBE(forward_be),
    .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
    .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m),
    .MultiBusy(multi_busy), .MultiDoneE(multi_done_e), .StallCycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles the current multi-cycle op has spent in E (0 = none).
  int age  = 0;
  int perf = 0;

  // Last sampled DUT values, for directed checks.
  logic [7:0]    last_ctl;
  logic [1:0]    last_fa, last_fb;
  logic [PB-1:0] last_sc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [1:0] model_fwd(input logic [RA-1:0] ra);
    if (ra == 4'd15)                          return 2'b00;
    else if (reg_write_m && (wa3m == ra))     return 2'b10;
    else if (reg_write_w && (wa3w == ra))     return 2'b01;
    else                                      return 2'b00;
  endfunction

  // One clock: check every output against the model at negedge, then advance the model.
  task automatic run_cycle(input string tag);
    logic       busy, done, ld, br, sd;
    logic [1:0] fa, fb;
    logic [7:0] ctl;
    busy = (age >= 1) && (age <= L - 2);
    done = (age == L - 1);
    br   = branch_taken_e;
    ld   = mem_to_reg_e && ((wa3e == ra1d) || (wa3e == ra2d));
    if (!reset) begin
      fa  = 2'b00;
      fb  = 2'b00;
      ctl = 8'b000_111_00;
    end else begin
      fa = model_fwd(ra1e);
      fb = model_fwd(ra2e);
      if (busy) ctl = 8'b111_001_10;
      else      ctl = {ld && !br, ld && !br, 1'b0, br, ld || br, 1'b0, 1'b0, done};
    end
    @(negedge clk);
    last_ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, multi_busy, multi_done_e};
    last_fa  = forward_ae;
    last_fb  = forward_be;
    last_sc  = stall_cycles;
    check_val({tag, ".fwd"},  {28'd0, last_fa, last_fb}, {28'd0, fa, fb});
    check_val({tag, ".ctl"},  {24'd0, last_ctl}, {24'd0, ctl});
    check_val({tag, ".perf"}, {26'd0, last_sc}, perf);
    sd = ctl[6];
    if (!reset) begin
      age  = 0;
      perf = 0;
    end else begin
      if (sd && perf < PERF_MAX) perf++;
      if (busy)                          age++;
      else if (multi_start_e && !br)     age = 1;
      else                               age = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 1'b1;
    {ra1d, ra2d, ra1e, ra2e} = '0;
    wa3e = 4'd1; wa3m = 4'd2; wa3w = 4'd4;
    ra1d = 4'd8; ra2d = 4'd9; ra1e = 4'd10; ra2e = 4'd11;
    {reg_write_m, reg_write_w, mem_to_reg_e, branch_taken_e, multi_start_e} = '0;
  endtask

  task automatic start_pulse_cycle(input string tag);
    multi_start_e = 1'b1;
    run_cycle(tag);
    multi_start_e = 1'b0;
  endtask

  initial begin
    logic [PB-1:0] sc0;
    clr();
    reset = 1'b0;
    run_cycle("rst0");
    run_cycle("rst1");
    check_val("rst_flush", {24'd0, last_ctl}, 32'h1C);
    reset = 1'b1;

    // Forwarding priority and R15 exclusion
    reg_write_m = 1'b1; wa3m = 4'd3; ra1e = 4'd3;
    run_cycle("fwd_m");
    check_val("fwd_m_sel", {30'd0, last_fa}, 32'd2);
    reg_write_w = 1'b1; wa3w = 4'd3;
    run_cycle("fwd_mw");
    check_val("fwd_mw_sel", {30'd0, last_fa}, 32'd2);
    reg_write_m = 1'b0;
    run_cycle("fwd_w");
    check_val("fwd_w_sel", {30'd0, last_fa}, 32'd1);
    reg_write_m = 1'b1; wa3m = 4'd15; wa3w = 4'd15; ra1e = 4'd15;
    run_cycle("fwd_r15");
    check_val("fwd_r15_sel", {30'd0, last_fa}, 32'd0);
    clr();

    // Load-use bubble, then branch overriding it
    mem_to_reg_e = 1'b1; wa3e = 4'd5; ra2d = 4'd5;
    run_cycle("ldu");
    check_val("ldu_ctl", {24'd0, last_ctl}, 32'hC8);
    check_val("ldu_sc0", {26'd0, last_sc}, 32'd0);
    branch_taken_e = 1'b1;
    run_cycle("br_ldu");
    check_val("br_ldu_ctl", {24'd0, last_ctl}, 32'h18);
    check_val("ldu_sc1", {26'd0, last_sc}, 32'd1);
    clr();

    // Single multi-cycle op
    start_pulse_cycle("mc0");
    sc0 = last_sc;
    run_cycle("mc1");
    check_val("mc1_ctl", {24'd0, last_ctl}, 32'hE6);
    run_cycle("mc2");
    check_val("mc2_ctl", {24'd0, last_ctl}, 32'hE6);
    run_cycle("mc3");
    check_val("mc3_done", {24'd0, last_ctl}, 32'h01);
    run_cycle("mc4");
    check_val("mc4_idle", {24'd0, last_ctl}, 32'h00);
    check_val("mc_stall2", {26'd0, last_sc - sc0}, 32'd2);

    // Back-to-back ops: restart during DONE
    start_pulse_cycle("bb0");
    run_cycle("bb1");
    run_cycle("bb2");
    start_pulse_cycle("bb3");
    check_val("bb3_done", {24'd0, last_ctl}, 32'h01);
    run_cycle("bb4");
    check_val("bb4_busy", {24'd0, last_ctl}, 32'hE6);
    run_cycle("bb5");
    run_cycle("bb6");
    check_val("bb6_done", {24'd0, last_ctl}, 32'h01);

    // Reset mid-BUSY aborts the op
    start_pulse_cycle("rb0");
    run_cycle("rb1");
    reset = 1'b0;
    run_cycle("rb2");
    check_val("rb2_flush", {24'd0, last_ctl}, 32'h1C);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle("rb_after");
      check_val("rb_no_done", {31'd0, last_ctl[0]}, 32'd0);
    end
    check_val("rb_sc", {26'd0, last_sc}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) != 0);
      ra1d           = 4'($urandom_range(0, 15));
      ra2d           = 4'($urandom_range(0, 15));
      ra1e           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      ra2e           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      wa3e           = 4'($urandom_range(0, 15));
      wa3m           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      wa3w           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      reg_write_m    = 1'($urandom_range(0, 1));
      reg_write_w    = 1'($urandom_range(0, 1));
      mem_to_reg_e   = ($urandom_range(0, 2) == 0);
      branch_taken_e = ($urandom_range(0, 5) == 0);
      multi_start_e  = ($urandom_range(0, 3) == 0);
      run_cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
